// File: rtl/codec_intf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : codec_intf                                                   |
// | Description : Codec-side serial interface for the stereo equalizer.        |
// |               Derives MCLK/SCLK/LRCLK and the codec reset from a 10-bit    |
// |               free-running frame counter. Deserializes left-justified     |
// |               16-bit stereo samples from the ADC and serializes the        |
// |               processed samples to the DAC.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk      in   system clock, rising edge                                  |
// |   rst      in   asynchronous active-high reset                             |
// |   lft_in   in   [15:0] processed left sample to transmit                   |
// |   rht_in   in   [15:0] processed right sample to transmit                  |
// |   RSDATA   in   serial data from the codec ADC                             |
// |   lft_out  out  [15:0] last received left sample                          |
// |   rht_out  out  [15:0] last received right sample                         |
// |   valid    out  one-clk strobe, new lft_out/rht_out pair available        |
// |   LRCLK    out  frame clock (low = left half, high = right half)           |
// |   SCLK     out  bit clock                                                  |
// |   MCLK     out  codec master clock                                         |
// |   SDout    out  serial data to the codec DAC                               |
// |   RSTn     out  codec reset, active low                                    |
// +----------------------------------------------------------------------------+
module codec_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lft_in,
  input  logic [15:0] rht_in,
  input  logic        RSDATA,
  output logic [15:0] lft_out,
  output logic [15:0] rht_out,
  output logic        valid,
  output logic        LRCLK,
  output logic        SCLK,
  output logic        MCLK,
  output logic        SDout,
  output logic        RSTn
);

  localparam logic [9:0] CNT_LAST   = 10'h3FF;  // last clk of a stereo frame
  localparam logic [9:0] CNT_UPDATE = 10'h3F0;  // one clk after the R LSB is sampled
  localparam logic [4:0] SCLK_RISE  = 5'h0F;    // edge on which SCLK goes high
  localparam logic [4:0] SCLK_FALL  = 5'h1F;    // edge on which SCLK goes low

  logic [9:0]  cnt_q, cnt_d;
  logic        rstn_q, rstn_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] lft_out_q, lft_out_d;
  logic [15:0] rht_out_q, rht_out_d;
  logic        valid_q, valid_d;

  logic        w_frame_end;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_update;

  assign w_frame_end = (cnt_q == CNT_LAST);
  assign w_sclk_rise = (cnt_q[4:0] == SCLK_RISE);
  assign w_sclk_fall = (cnt_q[4:0] == SCLK_FALL);
  // The frame that elapses while the codec is still held in reset is never reported.
  assign w_update    = (cnt_q == CNT_UPDATE) && rstn_q;

  always_comb begin
    cnt_d     = cnt_q + 10'd1;
    // Sticky: once the codec leaves reset it stays out until rst.
    rstn_d    = rstn_q | w_frame_end;

    rx_d      = rx_q;
    if (w_sclk_rise) begin
      rx_d = {rx_q[30:0], RSDATA};
    end

    // The frame-end load coincides with an SCLK-fall edge; load must win.
    tx_d      = tx_q;
    if (w_frame_end) begin
      tx_d = {lft_in, rht_in};
    end else if (w_sclk_fall) begin
      tx_d = {tx_q[30:0], 1'b0};
    end

    lft_out_d = lft_out_q;
    rht_out_d = rht_out_q;
    valid_d   = 1'b0;
    if (w_update) begin
      lft_out_d = rx_q[31:16];
      rht_out_d = rx_q[15:0];
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rstn_q    <= 1'b0;
      rx_q      <= '0;
      tx_q      <= '0;
      lft_out_q <= '0;
      rht_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rstn_q    <= rstn_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      lft_out_q <= lft_out_d;
      rht_out_q <= rht_out_d;
      valid_q   <= valid_d;
    end
  end

  // Codec clocks are taken straight from counter flops so they cannot glitch.
  assign LRCLK   = cnt_q[9];
  assign SCLK    = cnt_q[4];
  assign MCLK    = cnt_q[1];
  assign RSTn    = rstn_q;
  assign SDout   = tx_q[31] & rstn_q;
  assign lft_out = lft_out_q;
  assign rht_out = rht_out_q;
  assign valid   = valid_q;

endmodule
`default_nettype wire
